// File: rtl/ctrl_pipeline_pkg.sv
// Shared control-path definitions: decoder encodings, forwarding selects and
// the control bundles carried through the ID/EX, EX/MEM and MEM/WB registers.
package ctrl_pipeline_pkg;

  localparam int unsigned REG_AW  = 5;
  localparam int unsigned ALUOP_W = 2;
  localparam int unsigned FWD_W   = 2;
  localparam int unsigned OPC_W   = 6;

  localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_OR    = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b10;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b11;

  localparam logic [FWD_W-1:0] FWD_RF  = 2'b00;
  localparam logic [FWD_W-1:0] FWD_MEM = 2'b10;
  localparam logic [FWD_W-1:0] FWD_WB  = 2'b01;

  localparam logic [OPC_W-1:0] OPC_R   = 6'b000000;
  localparam logic [OPC_W-1:0] OPC_ORI = 6'b001101;
  localparam logic [OPC_W-1:0] OPC_LW  = 6'b100011;
  localparam logic [OPC_W-1:0] OPC_SW  = 6'b101011;
  localparam logic [OPC_W-1:0] OPC_BEQ = 6'b000100;
  localparam logic [OPC_W-1:0] OPC_J   = 6'b000010;

  // Decoder output bundle for the instruction in ID.
  typedef struct packed {
    logic               reg_dst;
    logic               alu_src;
    logic               mem_to_reg;
    logic               reg_write;
    logic               mem_write;
    logic               branch;
    logic               jump;
    logic [ALUOP_W-1:0] alu_op;
  } ctrl_t;

  typedef struct packed {
    logic               reg_dst;
    logic               alu_src;
    logic               mem_to_reg;
    logic               reg_write;
    logic               mem_write;
    logic               branch;
    logic [ALUOP_W-1:0] alu_op;
    logic [REG_AW-1:0]  rs;
    logic [REG_AW-1:0]  rt;
    logic [REG_AW-1:0]  waddr;
  } idex_t;

  typedef struct packed {
    logic              mem_to_reg;
    logic              reg_write;
    logic              mem_write;
    logic [REG_AW-1:0] waddr;
  } exmem_t;

  typedef struct packed {
    logic              mem_to_reg;
    logic              reg_write;
    logic [REG_AW-1:0] waddr;
  } memwb_t;

  // R-type writes rd, everything else writes rt.
  function automatic logic [REG_AW-1:0] dest_addr(input logic reg_dst,
                                                  input logic [REG_AW-1:0] rt,
                                                  input logic [REG_AW-1:0] rd);
    return reg_dst ? rd : rt;
  endfunction

endpackage

// File: rtl/ctrl_pipeline_hazard_fwd_unit.sv
// Combinational load-use detection and EX operand forwarding selects.
module hazard_fwd_unit
  import ctrl_pipeline_pkg::*;
(
  input  logic              ex_mem_to_reg,
  input  logic              ex_reg_write,
  input  logic [REG_AW-1:0] ex_waddr,
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_reg_dst,
  input  logic              id_mem_write,
  input  logic              id_branch,
  input  logic              id_jump,
  input  logic              mem_reg_write,
  input  logic              mem_mem_to_reg,
  input  logic [REG_AW-1:0] mem_waddr,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_waddr,
  output logic              load_use_c,
  output logic [FWD_W-1:0]  fwd_a_c,
  output logic [FWD_W-1:0]  fwd_b_c
);

  logic uses_rt_c;
  logic ex_load_c;

  // Loads are not forwardable from MEM; their data only exists from WB on.
  function automatic logic [FWD_W-1:0] fwd_sel(input logic [REG_AW-1:0] src,
                                               input logic              m_rw,
                                               input logic              m_m2r,
                                               input logic [REG_AW-1:0] m_wa,
                                               input logic              w_rw,
                                               input logic [REG_AW-1:0] w_wa);
    logic [FWD_W-1:0] sel;
    sel = FWD_RF;
    if (m_rw && !m_m2r && (m_wa != '0) && (m_wa == src)) begin
      sel = FWD_MEM;
    end else if (w_rw && (w_wa != '0) && (w_wa == src)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

  always_comb begin
    uses_rt_c  = id_reg_dst | id_mem_write | id_branch;
    ex_load_c  = ex_mem_to_reg & ex_reg_write & (ex_waddr != '0);
    load_use_c = ex_load_c & ~id_jump &
                 ((ex_waddr == id_rs) | (uses_rt_c & (ex_waddr == id_rt)));
    fwd_a_c    = fwd_sel(ex_rs, mem_reg_write, mem_mem_to_reg, mem_waddr,
                         wb_reg_write, wb_waddr);
    fwd_b_c    = fwd_sel(ex_rt, mem_reg_write, mem_mem_to_reg, mem_waddr,
                         wb_reg_write, wb_waddr);
  end

endmodule

// File: rtl/ctrl_pipeline.sv
// Control half of the 5-stage pipeline: ID/EX, EX/MEM, MEM/WB control
// registers plus stall, squash and PC-select generation.
module ctrl_pipeline
  import ctrl_pipeline_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_reg_dst,
  input  logic               id_alu_src,
  input  logic               id_mem_to_reg,
  input  logic               id_reg_write,
  input  logic               id_mem_write,
  input  logic               id_branch,
  input  logic               id_jump,
  input  logic [ALUOP_W-1:0] id_alu_op,
  input  logic [REG_AW-1:0]  id_rs,
  input  logic [REG_AW-1:0]  id_rt,
  input  logic [REG_AW-1:0]  id_rd,
  input  logic               ex_zero,
  output logic               ex_alu_src,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic               ex_reg_dst,
  output logic [FWD_W-1:0]   forward_a,
  output logic [FWD_W-1:0]   forward_b,
  output logic               mem_mem_read,
  output logic               mem_mem_write,
  output logic               wb_reg_write,
  output logic               wb_mem_to_reg,
  output logic [REG_AW-1:0]  wb_waddr,
  output logic               pc_write,
  output logic               ifid_write,
  output logic               ifid_flush,
  output logic               pc_src_branch,
  output logic               pc_src_jump
);

  ctrl_t  id_ctrl;
  idex_t  idex_q, idex_d;
  exmem_t exmem_q, exmem_d;
  memwb_t memwb_q, memwb_d;

  logic branch_taken_c;
  logic load_use_c;
  logic stall_c;
  logic jump_c;

  always_comb begin
    id_ctrl            = '0;
    id_ctrl.reg_dst    = id_reg_dst;
    id_ctrl.alu_src    = id_alu_src;
    id_ctrl.mem_to_reg = id_mem_to_reg;
    id_ctrl.reg_write  = id_reg_write;
    id_ctrl.mem_write  = id_mem_write;
    id_ctrl.branch     = id_branch;
    id_ctrl.jump       = id_jump;
    id_ctrl.alu_op     = id_alu_op;
  end

  hazard_fwd_unit u_hazard_fwd (
    .ex_mem_to_reg  (idex_q.mem_to_reg),
    .ex_reg_write   (idex_q.reg_write),
    .ex_waddr       (idex_q.waddr),
    .ex_rs          (idex_q.rs),
    .ex_rt          (idex_q.rt),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_reg_dst     (id_ctrl.reg_dst),
    .id_mem_write   (id_ctrl.mem_write),
    .id_branch      (id_ctrl.branch),
    .id_jump        (id_ctrl.jump),
    .mem_reg_write  (exmem_q.reg_write),
    .mem_mem_to_reg (exmem_q.mem_to_reg),
    .mem_waddr      (exmem_q.waddr),
    .wb_reg_write   (memwb_q.reg_write),
    .wb_waddr       (memwb_q.waddr),
    .load_use_c     (load_use_c),
    .fwd_a_c        (forward_a),
    .fwd_b_c        (forward_b)
  );

  // A taken branch makes the ID instruction wrong-path, so it overrides both
  // the stall and a jump sitting in ID.
  assign branch_taken_c = idex_q.branch & ex_zero;
  assign stall_c        = load_use_c & ~branch_taken_c;
  assign jump_c         = id_ctrl.jump & ~branch_taken_c;

  // ID/EX next value: bubble on squash, stall, or jump (jump has no EX work).
  always_comb begin
    idex_d = '0;
    if (!(branch_taken_c || stall_c || id_ctrl.jump)) begin
      idex_d.reg_dst    = id_ctrl.reg_dst;
      idex_d.alu_src    = id_ctrl.alu_src;
      idex_d.mem_to_reg = id_ctrl.mem_to_reg;
      idex_d.reg_write  = id_ctrl.reg_write;
      idex_d.mem_write  = id_ctrl.mem_write;
      idex_d.branch     = id_ctrl.branch;
      idex_d.alu_op     = id_ctrl.alu_op;
      idex_d.rs         = id_rs;
      idex_d.rt         = id_rt;
      idex_d.waddr      = dest_addr(id_ctrl.reg_dst, id_rt, id_rd);
    end
  end

  always_comb begin
    exmem_d            = '0;
    exmem_d.mem_to_reg = idex_q.mem_to_reg;
    exmem_d.reg_write  = idex_q.reg_write;
    exmem_d.mem_write  = idex_q.mem_write;
    exmem_d.waddr      = idex_q.waddr;

    memwb_d            = '0;
    memwb_d.mem_to_reg = exmem_q.mem_to_reg;
    memwb_d.reg_write  = exmem_q.reg_write;
    memwb_d.waddr      = exmem_q.waddr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

  assign ex_alu_src    = idex_q.alu_src;
  assign ex_alu_op     = idex_q.alu_op;
  assign ex_reg_dst    = idex_q.reg_dst;
  assign mem_mem_read  = exmem_q.mem_to_reg;
  assign mem_mem_write = exmem_q.mem_write;
  assign wb_reg_write  = memwb_q.reg_write;
  assign wb_mem_to_reg = memwb_q.mem_to_reg;
  assign wb_waddr      = memwb_q.waddr;

  assign pc_write      = ~stall_c;
  assign ifid_write    = ~stall_c;
  assign ifid_flush    = branch_taken_c | jump_c;
  assign pc_src_branch = branch_taken_c;
  assign pc_src_jump   = jump_c;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Cycle-by-cycle instruction stream with hand-derived control outputs,
// followed by an asynchronous reset taken while a load is in flight.
module tb_ctrl_pipeline;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_reg_dst, id_alu_src, id_mem_to_reg, id_reg_write;
  logic       id_mem_write, id_branch, id_jump;
  logic [1:0] id_alu_op;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       ex_zero;
  logic       ex_alu_src, ex_reg_dst;
  logic [1:0] ex_alu_op, forward_a, forward_b;
  logic       mem_mem_read, mem_mem_write, wb_reg_write, wb_mem_to_reg;
  logic [4:0] wb_waddr;
  logic       pc_write, ifid_write, ifid_flush, pc_src_branch, pc_src_jump;

  always #5 clk = ~clk;

  ctrl_pipeline dut (
    .clk(clk), .rst_n(rst_n),
    .id_reg_dst(id_reg_dst), .id_alu_src(id_alu_src), .id_mem_to_reg(id_mem_to_reg),
    .id_reg_write(id_reg_write), .id_mem_write(id_mem_write), .id_branch(id_branch),
    .id_jump(id_jump), .id_alu_op(id_alu_op), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .ex_zero(ex_zero), .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op), .ex_reg_dst(ex_reg_dst),
    .forward_a(forward_a), .forward_b(forward_b), .mem_mem_read(mem_mem_read),
    .mem_mem_write(mem_mem_write), .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
    .wb_waddr(wb_waddr), .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .pc_src_branch(pc_src_branch), .pc_src_jump(pc_src_jump)
  );

  typedef struct packed {
    logic       reg_dst, alu_src, mem_to_reg, reg_write, mem_write, branch, jump;
    logic [1:0] alu_op;
    logic [4:0] rs, rt, rd;
  } instr_t;

  // hz = {pc_write, ifid_write, ifid_flush, pc_src_branch, pc_src_jump}
  typedef struct packed {
    logic       ex_src;
    logic [1:0] ex_op;
    logic       ex_dst;
    logic [1:0] fa, fb;
    logic       mr, mw, wrw, wm2r;
    logic [4:0] wa;
    logic [4:0] hz;
  } outs_t;

  typedef struct {
    instr_t ins;
    logic   zero;
    outs_t  exp;
  } vec_t;

  localparam logic [4:0] RUN   = 5'b11000;
  localparam logic [4:0] STALL = 5'b00000;
  localparam logic [4:0] BR    = 5'b11110;
  localparam logic [4:0] JMP   = 5'b11101;

  vec_t  vecs[$];
  outs_t act;
  int    n_pass = 0;
  int    n_total = 0;

  assign act = {ex_alu_src, ex_alu_op, ex_reg_dst, forward_a, forward_b,
                mem_mem_read, mem_mem_write, wb_reg_write, wb_mem_to_reg, wb_waddr,
                pc_write, ifid_write, ifid_flush, pc_src_branch, pc_src_jump};

  function automatic instr_t mk(int dst, int src, int m2r, int rw, int mw, int br,
                                int jmp, int op, int rs, int rt, int rd);
    instr_t i;
    i.reg_dst = 1'(dst); i.alu_src = 1'(src); i.mem_to_reg = 1'(m2r);
    i.reg_write = 1'(rw); i.mem_write = 1'(mw); i.branch = 1'(br); i.jump = 1'(jmp);
    i.alu_op = 2'(op); i.rs = 5'(rs); i.rt = 5'(rt); i.rd = 5'(rd);
    return i;
  endfunction

  function automatic instr_t i_r(int rd, int rs, int rt);  return mk(1,0,0,1,0,0,0,0,rs,rt,rd); endfunction
  function automatic instr_t i_ori(int rt, int rs);        return mk(0,1,0,1,0,0,0,1,rs,rt,0);  endfunction
  function automatic instr_t i_lw(int rt, int rs);         return mk(0,1,1,1,0,0,0,2,rs,rt,0);  endfunction
  function automatic instr_t i_sw(int rt, int rs);         return mk(0,1,0,0,1,0,0,2,rs,rt,0);  endfunction
  function automatic instr_t i_beq(int rs, int rt);        return mk(0,0,0,0,0,1,0,3,rs,rt,0);  endfunction
  function automatic instr_t i_j();                        return mk(0,0,0,0,0,0,1,0,0,0,0);    endfunction
  function automatic instr_t i_nop();                      return mk(0,0,0,0,0,0,0,0,0,0,0);    endfunction

  // Forward select values: 2 = EX/MEM, 1 = MEM/WB, 0 = register file.
  function automatic outs_t o(int s, int op, int d, int fa, int fb, int mr, int mw,
                              int rw, int m2r, int wa, logic [4:0] hz);
    outs_t r;
    r.ex_src = 1'(s); r.ex_op = 2'(op); r.ex_dst = 1'(d); r.fa = 2'(fa); r.fb = 2'(fb);
    r.mr = 1'(mr); r.mw = 1'(mw); r.wrw = 1'(rw); r.wm2r = 1'(m2r); r.wa = 5'(wa);
    r.hz = hz;
    return r;
  endfunction

  task automatic add(input instr_t ins, input int zero, input outs_t exp);
    vec_t v;
    v.ins = ins; v.zero = 1'(zero); v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic drive(input instr_t i, input logic z);
    id_reg_dst = i.reg_dst; id_alu_src = i.alu_src; id_mem_to_reg = i.mem_to_reg;
    id_reg_write = i.reg_write; id_mem_write = i.mem_write; id_branch = i.branch;
    id_jump = i.jump; id_alu_op = i.alu_op; id_rs = i.rs; id_rt = i.rt; id_rd = i.rd;
    ex_zero = z;
  endtask

  task automatic check(input string name, input outs_t exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  initial begin
    drive(i_nop(), 1'b0);

    // Pass-through of an R-type, then MEM-over-WB forwarding and $0 handling.
    add(i_r(3,1,2),   0, o(0,0,0, 0,0, 0,0, 0,0,0,  RUN));
    add(i_nop(),      0, o(0,0,1, 0,0, 0,0, 0,0,0,  RUN));
    add(i_nop(),      0, o(0,0,0, 0,0, 0,0, 0,0,0,  RUN));
    add(i_nop(),      0, o(0,0,0, 0,0, 0,0, 1,0,3,  RUN));
    add(i_r(1,7,8),   0, o(0,0,0, 0,0, 0,0, 0,0,0,  RUN));
    add(i_r(1,9,10),  0, o(0,0,1, 0,0, 0,0, 0,0,0,  RUN));
    add(i_r(6,1,1),   0, o(0,0,1, 0,0, 0,0, 0,0,0,  RUN));
    add(i_nop(),      0, o(0,0,1, 2,2, 0,0, 1,0,1,  RUN));
    add(i_nop(),      0, o(0,0,0, 0,0, 0,0, 1,0,1,  RUN));
    add(i_r(0,1,2),   0, o(0,0,0, 0,0, 0,0, 1,0,6,  RUN));
    add(i_r(5,0,0),   0, o(0,0,1, 0,0, 0,0, 0,0,0,  RUN));
    add(i_nop(),      0, o(0,0,1, 0,0, 0,0, 0,0,0,  RUN));
    add(i_nop(),      0, o(0,0,0, 0,0, 0,0, 1,0,0,  RUN));
    // Load-use on rs: one stall cycle, then WB forwarding.
    add(i_lw(2,3),    0, o(0,0,0, 0,0, 0,0, 1,0,5,  RUN));
    add(i_r(4,2,5),   0, o(1,2,0, 0,0, 0,0, 0,0,0,  STALL));
    add(i_r(4,2,5),   0, o(0,0,0, 0,0, 1,0, 0,0,0,  RUN));
    add(i_nop(),      0, o(0,0,1, 1,0, 0,0, 1,1,2,  RUN));
    // Load feeding a beq, taken branch squashing ID, jump, branch over jump.
    add(i_lw(8,1),    0, o(0,0,0, 0,0, 0,0, 0,0,0,  RUN));
    add(i_beq(8,9),   0, o(1,2,0, 0,0, 0,0, 1,0,4,  STALL));
    add(i_beq(8,9),   0, o(0,0,0, 0,0, 1,0, 0,0,0,  RUN));
    add(i_r(11,8,8),  1, o(0,3,0, 1,0, 0,0, 1,1,8,  BR));
    add(i_j(),        0, o(0,0,0, 0,0, 0,0, 0,0,0,  JMP));
    add(i_beq(1,1),   0, o(0,0,0, 0,0, 0,0, 0,0,9,  RUN));
    add(i_j(),        1, o(0,3,0, 0,0, 0,0, 0,0,0,  BR));
    add(i_nop(),      0, o(0,0,0, 0,0, 0,0, 0,0,0,  RUN));
    add(i_nop(),      0, o(0,0,0, 0,0, 0,0, 0,0,1,  RUN));
    // Store, rt-only dependences, loads to $0, not-taken branch.
    add(i_sw(4,2),    0, o(0,0,0, 0,0, 0,0, 0,0,0,  RUN));
    add(i_nop(),      0, o(1,2,0, 0,0, 0,0, 0,0,0,  RUN));
    add(i_nop(),      0, o(0,0,0, 0,0, 0,1, 0,0,0,  RUN));
    add(i_lw(9,3),    0, o(0,0,0, 0,0, 0,0, 0,0,4,  RUN));
    add(i_ori(9,3),   0, o(1,2,0, 0,0, 0,0, 0,0,0,  RUN));
    add(i_lw(10,3),   0, o(1,1,0, 0,0, 1,0, 0,0,0,  RUN));
    add(i_sw(10,3),   0, o(1,2,0, 0,0, 0,0, 1,1,9,  STALL));
    add(i_sw(10,3),   0, o(0,0,0, 0,0, 1,0, 1,0,9,  RUN));
    add(i_lw(0,3),    0, o(1,2,0, 0,1, 0,0, 1,1,10, RUN));
    add(i_r(5,0,0),   0, o(1,2,0, 0,0, 0,1, 0,0,0,  RUN));
    add(i_beq(2,3),   0, o(0,0,1, 0,0, 1,0, 0,0,10, RUN));
    add(i_r(1,2,3),   0, o(0,3,0, 0,0, 0,0, 1,1,0,  RUN));
    add(i_nop(),      0, o(0,0,1, 0,0, 0,0, 1,0,5,  RUN));

    // Reset state.
    repeat (2) @(negedge clk);
    #2 check("reset_idle", o(0,0,0, 0,0, 0,0, 0,0,0, RUN));
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      drive(vecs[k].ins, vecs[k].zero);
      #2 check($sformatf("vec%0d", k), vecs[k].exp);
    end

    // Asynchronous reset while a load sits in MEM.
    @(negedge clk); drive(i_lw(7,1), 1'b0);
    @(negedge clk); drive(i_nop(), 1'b0);
    @(negedge clk);
    #2 check("lw_in_mem", o(0,0,0, 0,0, 1,0, 0,0,0, RUN));
    rst_n = 1'b0;
    #1 check("async_reset_drop", o(0,0,0, 0,0, 0,0, 0,0,0, RUN));
    @(negedge clk);
    rst_n = 1'b1;
    #2 check("after_reset_wb", o(0,0,0, 0,0, 0,0, 0,0,0, RUN));
    @(negedge clk);
    #2 check("after_reset_wb2", o(0,0,0, 0,0, 0,0, 0,0,0, RUN));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
